// File: rtl/fifo_axi_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream FIFO write port between two sources.
// Holds the grant for a whole packet, caps packets at MaxPkt beats and drops any overflow.
module fifo_axi_rr_arbiter #(
    parameter int DataWidth = 16,
    parameter int MaxPkt    = 2048,
    parameter int CntWidth  = $clog2(MaxPkt + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] s0_data,
    input  logic                 s0_valid,
    input  logic                 s0_last,
    output logic                 s0_ready,
    input  logic [DataWidth-1:0] s1_data,
    input  logic                 s1_valid,
    input  logic                 s1_last,
    output logic                 s1_ready,
    input  logic                 fifo_full,
    output logic [DataWidth-1:0] m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic [1:0]           grant,
    output logic                 trunc
);

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DROP
    } state_t;

    state_t                 state, state_nxt;
    logic [1:0]             grant_nxt;
    logic                   last_grant, last_grant_nxt;
    logic [CntWidth-1:0]    beat_cnt, beat_cnt_nxt;

    logic                   owner;
    logic                   own_valid;
    logic                   own_last;
    logic [DataWidth-1:0]   own_data;
    logic                   own_ready;
    logic                   xfer;
    logic                   load;
    logic                   at_max;

    // grant[1] set means source 1 owns the port; only meaningful in PASS/DROP
    assign owner     = grant[1];
    assign own_valid = owner ? s1_valid : s0_valid;
    assign own_last  = owner ? s1_last  : s0_last;
    assign own_data  = owner ? s1_data  : s0_data;
    assign at_max    = (beat_cnt == CntWidth'(MaxPkt - 1));

    always_comb begin
        own_ready = 1'b0;
        case (state)
            PASS:    own_ready = !fifo_full && (!m_valid || m_ready);
            DROP:    own_ready = 1'b1;
            default: own_ready = 1'b0;
        endcase
        own_ready = own_ready && rst;
    end

    assign s0_ready = own_ready && grant[0];
    assign s1_ready = own_ready && grant[1];
    assign xfer     = own_valid && own_ready;
    assign load     = xfer && (state == PASS);

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        case (state)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    state_nxt = PASS;
                    if (s0_valid && s1_valid)
                        grant_nxt = last_grant ? 2'b01 : 2'b10;
                    else
                        grant_nxt = s0_valid ? 2'b01 : 2'b10;
                end else if (!m_valid) begin
                    grant_nxt = 2'b00;
                end
            end
            PASS: begin
                if (load) begin
                    if (own_last) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = owner;
                        beat_cnt_nxt   = '0;
                    end else if (at_max) begin
                        state_nxt    = DROP;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CntWidth'(1);
                    end
                end
            end
            DROP: begin
                if (xfer && own_last) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = owner;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output register is loaded only from PASS beats; it holds while the FIFO stalls it
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            trunc      <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
            if (load) begin
                m_data  <= own_data;
                m_valid <= 1'b1;
                m_last  <= own_last || at_max;
                trunc   <= !own_last && at_max;
            end else begin
                trunc <= 1'b0;
                if (m_ready) begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            end
        end
    end

endmodule
